// File: rtl/clock_gen_pkg.sv
// -----------------------------------------------------------------------------
// clock_gen_pkg
// Shared definitions for the clock-enable generator:
//   - default width of the divide-ratio / phase fields
//   - default number of refclk cycles needed to declare lock
//   - lock state machine encoding
// -----------------------------------------------------------------------------
package clock_gen_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int LOCK_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    LK_WAIT   = 2'd0,
    LK_COUNT  = 2'd1,
    LK_LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel. A free-running counter walks 0..div-1 and produces:
//   - ce_o  : one-cycle enable, high in the cycle after the counter wraps
//   - clk_o : registered square wave, high in the cycle after cnt < div/2
// A load request replaces the ratio and starting count and blanks both
// outputs for the following cycle, taking priority over a coincident wrap.
//
// Ports
//   refclk   : clock, rising edge
//   rst_n_i  : asynchronous active-low reset (already release-synchronised)
//   load_i   : load div_i / phase_i this cycle
//   div_i    : requested divide ratio (0 is treated as 1)
//   phase_i  : requested starting count (clamped to div-1)
//   ce_o     : clock-enable pulse
//   clk_o    : square wave
// -----------------------------------------------------------------------------
module clk_div_channel #(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2)
) (
  input  logic             refclk,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             ce_o,
  output logic             clk_o
);

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                   input logic [DIV_W-1:0] d);
    return (p > (d - DIV_W'(1))) ? (d - DIV_W'(1)) : p;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic             clk_q, clk_d;
  logic [DIV_W-1:0] new_div;
  logic             wrap;

  assign new_div = eff_div(div_i);
  // div_q is never zero, so div_q-1 is always a reachable terminal count.
  assign wrap    = (cnt_q == (div_q - DIV_W'(1)));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    ce_d  = 1'b0;
    clk_d = 1'b0;
    if (load_i) begin
      div_d = new_div;
      cnt_d = clamp_phase(phase_i, new_div);
    end else begin
      cnt_d = wrap ? '0 : (cnt_q + DIV_W'(1));
      ce_d  = wrap;
      clk_d = (cnt_q < (div_q >> 1));
    end
  end

  always_ff @(posedge refclk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q <= eff_div(RST_DIV);
      cnt_q <= '0;
      ce_q  <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
      clk_q <= clk_d;
    end
  end

  assign ce_o  = ce_q;
  assign clk_o = clk_q;

endmodule

// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
// Multi-channel clock-enable generator on a single reference clock. Each
// channel divides refclk by a runtime-configurable ratio and emits a one-cycle
// enable plus a registered square wave; no derived clocks are created.
// A lock state machine reports when every channel has run LOCK_CYCLES cycles
// at its current configuration.
//
// Ports
//   refclk    : sole clock, rising edge
//   rst       : asynchronous active-low reset (release synchronised inside)
//   cfg_valid : reconfiguration request
//   cfg_ready : request accepted in any cycle where cfg_valid is also high
//   cfg_ch    : target channel
//   cfg_div   : new divide ratio (0 treated as 1)
//   cfg_phase : new starting count (clamped to div-1)
//   ce_out    : per-channel clock-enable pulses
//   clk_out   : per-channel square waves
//   locked    : all channels stable at the current configuration
//   cfg_err   : one-cycle pulse after a request to a non-existent channel
// -----------------------------------------------------------------------------
module clock_enable_gen
  import clock_gen_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      DIV_W       = DIV_W_DEF,
  parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = {NUM_CH{DIV_W'(2)}},
  parameter int                      LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked,
  output logic              cfg_err
);

  localparam int                LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]    LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]     NUM_CH_X  = (CH_W + 1)'(NUM_CH);

  // ---------------------------------------------------------------------------
  // Reset: asserted asynchronously, released through two refclk flops so that
  // every register leaves reset on the same edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Handshake and error
  // ---------------------------------------------------------------------------
  logic ready_q;
  logic err_q, err_d;
  logic accept;
  logic ch_bad;
  logic cfg_ok;

  assign accept = cfg_valid && ready_q;
  assign ch_bad = ({1'b0, cfg_ch} >= NUM_CH_X);
  assign cfg_ok = accept && !ch_bad;
  assign err_d  = accept && ch_bad;

  // ready_q first rises on the edge after internal release, so the cycle in
  // which the lock FSM sits in WAIT never accepts a request.
  always_ff @(posedge refclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  lock_state_e    state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      LK_WAIT: begin
        state_d    = LK_COUNT;
        lock_cnt_d = '0;
      end
      LK_COUNT: begin
        if (cfg_ok) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d = LK_LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      LK_LOCKED: begin
        if (cfg_ok) begin
          state_d    = LK_COUNT;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = LK_WAIT;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= LK_WAIT;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked = (state_q == LK_LOCKED);

  // ---------------------------------------------------------------------------
  // Divider channels
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic load;

    assign load = cfg_ok && (cfg_ch == CH_W'(g));

    clk_div_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (DEFAULT_DIV[g*DIV_W +: DIV_W])
    ) u_ch (
      .refclk  (refclk),
      .rst_n_i (rst_n_int),
      .load_i  (load),
      .div_i   (cfg_div),
      .phase_i (cfg_phase),
      .ce_o    (ce_out[g]),
      .clk_o   (clk_out[g])
    );
  end

endmodule
